// File: rtl/card_shoe_arbiter_if.sv
// Handshake bundle between the card shoe and its requesters / display logic.
// The master side drives the requests; the shoe (slave) drives acks and card data.
interface card_shoe_if;
    logic       p_req;
    logic       d_req;
    logic       shuffle_req;
    logic       p_ack;
    logic       d_ack;
    logic [3:0] card_value;
    logic [3:0] card_rank;
    logic [5:0] cards_left;
    logic       deck_empty;
    logic       busy;

    modport master (
        output p_req, d_req, shuffle_req,
        input  p_ack, d_ack, card_value, card_rank, cards_left, deck_empty, busy
    );

    modport slave (
        input  p_req, d_req, shuffle_req,
        output p_ack, d_ack, card_value, card_rank, cards_left, deck_empty, busy
    );
endinterface

// File: rtl/card_shoe_arbiter.sv
// Single-deck card shoe: round-robin player/dealer arbitration, LFSR-seeded scan, draw without replacement.
// Optional CARD_AUTO_RESHUFFLE_EN: an empty deck is reshuffled automatically before serving a pending draw.
module card_shoe_arbiter #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic            clk,
    input  logic            rst,
    card_shoe_if.slave      bus
);

    localparam logic [15:0] SEED_EFF  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [5:0]  DECK_SIZE = 6'd52;
    localparam logic [5:0]  LAST_IDX  = 6'd51;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEED    = 3'd1,
        ST_SCAN    = 3'd2,
        ST_DELIVER = 3'd3,
        ST_SHUFFLE = 3'd4
    } state_t;

    // Card index 0..51 maps to rank index 0..12 (index mod 13).
    function automatic logic [3:0] rank_idx_f(input logic [5:0] idx);
        if (idx >= 6'd39) begin
            return 4'(idx - 6'd39);
        end else if (idx >= 6'd26) begin
            return 4'(idx - 6'd26);
        end else if (idx >= 6'd13) begin
            return 4'(idx - 6'd13);
        end else begin
            return 4'(idx);
        end
    endfunction

    function automatic logic [3:0] value_f(input logic [3:0] ridx);
        if (ridx == 4'd0) begin
            return 4'd1;
        end else if (ridx <= 4'd8) begin
            return ridx + 4'd1;
        end else begin
            return 4'd10;
        end
    endfunction

    function automatic logic [5:0] seed_idx_f(input logic [5:0] raw);
        if (raw < DECK_SIZE) begin
            return raw;
        end else begin
            return raw - DECK_SIZE;
        end
    endfunction

    state_t      state_r;
    logic [15:0] lfsr_r;
    logic [51:0] used_r;
    logic [5:0]  scan_idx_r;
    logic [5:0]  scan_cnt_r;
    logic [5:0]  cards_left_r;
    logic        deck_empty_r;
    logic        p_ack_r;
    logic        d_ack_r;
    logic        grant_p_r;
    logic        last_grant_p_r;
    logic [3:0]  card_value_r;
    logic [3:0]  card_rank_r;
    logic        busy_r;
`ifdef CARD_AUTO_RESHUFFLE_EN
    logic        reshuffle_r;
`endif

    logic        grant_p_s;
    logic        used_bit_s;
    logic [3:0]  rank_idx_s;

    assign used_bit_s = used_r[scan_idx_r];
    assign rank_idx_s = rank_idx_f(scan_idx_r);

    // Round-robin pick: on a tie the requester not served last wins.
    always_comb begin
        grant_p_s = 1'b0;
        if (bus.p_req && bus.d_req) begin
            grant_p_s = ~last_grant_p_r;
        end else begin
            grant_p_s = bus.p_req;
        end
    end

    // Free-running Galois LFSR, held at the seed only while in reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_r <= SEED_EFF;
        end else begin
            lfsr_r <= {1'b0, lfsr_r[15:1]} ^ (lfsr_r[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    // Shoe FSM with registered acks, card data, counters and busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            used_r         <= 52'd0;
            scan_idx_r     <= 6'd0;
            scan_cnt_r     <= 6'd0;
            cards_left_r   <= DECK_SIZE;
            deck_empty_r   <= 1'b0;
            p_ack_r        <= 1'b0;
            d_ack_r        <= 1'b0;
            grant_p_r      <= 1'b0;
            last_grant_p_r <= 1'b0;
            card_value_r   <= 4'd0;
            card_rank_r    <= 4'd0;
            busy_r         <= 1'b0;
`ifdef CARD_AUTO_RESHUFFLE_EN
            reshuffle_r    <= 1'b0;
`endif
        end else begin
            p_ack_r <= 1'b0;
            d_ack_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.shuffle_req) begin
                        state_r <= ST_SHUFFLE;
                        busy_r  <= 1'b1;
                    end else if (bus.p_req || bus.d_req) begin
                        grant_p_r      <= grant_p_s;
                        last_grant_p_r <= grant_p_s;
                        state_r        <= ST_SEED;
                        busy_r         <= 1'b1;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_SEED: begin
                    scan_idx_r <= seed_idx_f(lfsr_r[5:0]);
                    scan_cnt_r <= 6'd0;
                    if (cards_left_r == 6'd0) begin
`ifdef CARD_AUTO_RESHUFFLE_EN
                        reshuffle_r <= 1'b1;
                        state_r     <= ST_SHUFFLE;
`else
                        card_value_r <= 4'd0;
                        card_rank_r  <= 4'd0;
                        p_ack_r      <= grant_p_r;
                        d_ack_r      <= ~grant_p_r;
                        state_r      <= ST_DELIVER;
`endif
                    end else begin
                        state_r <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (!used_bit_s) begin
                        used_r[scan_idx_r] <= 1'b1;
                        cards_left_r       <= cards_left_r - 6'd1;
                        deck_empty_r       <= (cards_left_r == 6'd1);
                        card_value_r       <= value_f(rank_idx_s);
                        card_rank_r        <= rank_idx_s + 4'd1;
                        p_ack_r            <= grant_p_r;
                        d_ack_r            <= ~grant_p_r;
                        state_r            <= ST_DELIVER;
                    end else if (scan_cnt_r == LAST_IDX) begin
                        // Unreachable while cards_left tracks used; fail safe with a null card.
                        card_value_r <= 4'd0;
                        card_rank_r  <= 4'd0;
                        p_ack_r      <= grant_p_r;
                        d_ack_r      <= ~grant_p_r;
                        state_r      <= ST_DELIVER;
                    end else begin
                        scan_idx_r <= (scan_idx_r == LAST_IDX) ? 6'd0 : scan_idx_r + 6'd1;
                        scan_cnt_r <= scan_cnt_r + 6'd1;
                    end
                end
                ST_DELIVER: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                ST_SHUFFLE: begin
                    used_r       <= 52'd0;
                    cards_left_r <= DECK_SIZE;
                    deck_empty_r <= 1'b0;
`ifdef CARD_AUTO_RESHUFFLE_EN
                    if (reshuffle_r) begin
                        reshuffle_r <= 1'b0;
                        state_r     <= ST_SEED;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
`else
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
`endif
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.p_ack      = p_ack_r;
    assign bus.d_ack      = d_ack_r;
    assign bus.card_value = card_value_r;
    assign bus.card_rank  = card_rank_r;
    assign bus.cards_left = cards_left_r;
    assign bus.deck_empty = deck_empty_r;
    assign bus.busy       = busy_r;

endmodule

// File: doc/card_shoe_arbiter.md
# card_shoe_arbiter

Single-deck card shoe that owns the 52-card deck and serves cards to two requesters, the player-hit path and the dealer-draw path. It arbitrates between them round-robin and draws without replacement using a free-running LFSR plus a bounded linear scan. It returns a blackjack point value (ace = 1, faces = 10) plus the rank to the game FSM's `card_value` input and to the display logic.

## Interface
Parameters:
- `LFSR_SEED`, default 16'hACE1: reset value of the 16-bit LFSR. A value of 0 is replaced by 16'h0001.

Ports:
- `clk`  in  1  system clock; one clock domain, all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `p_req`  in  1  player card request; held high until `p_ack`.
- `d_req`  in  1  dealer card request; held high until `d_ack`.
- `shuffle_req`  in  1  return all cards to the shoe.
- `p_ack`  out  1  one-cycle pulse: the card outputs belong to the player.
- `d_ack`  out  1  one-cycle pulse: the card outputs belong to the dealer.
- `card_value`  out  4  blackjack points 1..10, valid with an ack.
- `card_rank`  out  4  rank 1..13 (A..K), valid with an ack.
- `cards_left`  out  6  undealt cards, 0..52.
- `deck_empty`  out  1  high when `cards_left` == 0.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- Deck state:
  - 52-bit `used` map, bit i = card index i (0..51); rank = i mod 13.
  - rank idx 0 → value 1; idx 1..8 → value idx+1; idx 9..12 → value 10; `card_rank` = idx+1.
- LFSR: 16-bit Galois, taps 16'hB400. It advances every cycle except during reset, independent of state.
- States:
  - IDLE:
    - `shuffle_req` → SHUFFLE. This has priority over any request in the same cycle.
    - Else any request → grant one requester, then SEED.
    - Both requesters high → grant the one not granted last. `last_grant` resets to dealer, so the player wins the first tie.
  - SEED:
    - `scan_idx` ← lfsr[5:0] if < 52, else lfsr[5:0] − 52.
    - If `cards_left` == 0 → EMPTY handling (see Configuration).
    - Else → SCAN.
  - SCAN, one index per cycle:
    - If `used[scan_idx]` = 0 → set it, decrement `cards_left`, latch value/rank, → DELIVER.
    - Else `scan_idx` ← `scan_idx`+1, wrapping 51 → 0.
    - Scan is bounded at 52 cycles.
  - DELIVER: assert the granted ack for exactly one cycle with the card outputs, → IDLE.
  - SHUFFLE: clear `used`, `cards_left` ← 52, → IDLE (one cycle).
- `card_value`/`card_rank` hold their last delivered value until the next delivery.
- Requests not being served stay pending; nothing is queued beyond the level-held `req`.
- A requester still high in the cycle after its ack is treated as a new request.
- `shuffle_req` outside IDLE is ignored, not latched.
- Reset mid-operation (any state) returns everything to its reset value. A partially scanned card is not consumed.

## Timing
- Reset values:
  - Outputs: `p_ack` = `d_ack` = 0, `card_value` = `card_rank` = 0, `cards_left` = 52, `deck_empty` = 0, `busy` = 0.
  - Internal: `used` = 0, lfsr = seed, state IDLE.
- Latency from a request sampled in IDLE at edge t:
  - SEED during t+1, first SCAN during t+2.
  - Ack high during t+3+k, where k = number of used cards skipped (0..51).
- Fresh deck: ack at exactly t+3.
- Back-to-back: minimum 4 cycles per card, ack to next ack.
- `busy` rises the cycle after the granting edge and falls in the cycle after DELIVER.
- Shuffle: `shuffle_req` at t → `cards_left` = 52 and `busy` = 0 in cycle t+2.

## Configuration
- `CARD_AUTO_RESHUFFLE_EN` defined:
  - In SEED, with `cards_left` == 0 → perform a SHUFFLE cycle, then re-enter SEED and serve the pending grant.
  - This adds 2 cycles of latency. `deck_empty` pulses high only between the last deal and the reshuffle.
- Not defined:
  - In SEED, with `cards_left` == 0 → go directly to DELIVER with `card_value` = 0 and `card_rank` = 0.
  - The ack is still pulsed and `cards_left` stays 0.
  - `deck_empty` stays 1 until `shuffle_req`.

## Test plan
- Reset: after `rst` is held 2 cycles, check `cards_left` = 52, `deck_empty` = 0, `busy` = 0, both acks 0, `card_value` = 0.
- Single draw: `p_req` at edge t on a fresh deck → `p_ack` high only in cycle t+3, `card_value` in 1..10 consistent with `card_rank`, `cards_left` = 51.
- Full deck: 52 sequential player draws → every rank 1..13 seen exactly 4 times, no repeats, `cards_left` reaches 0, `deck_empty` = 1, every latency ≤ 3+51.
- Arbitration: `p_req` and `d_req` rise together and stay high → ack order P, D, P, D; each ack is one cycle; `cards_left` decreases by 1 per ack.
- Empty deck, 53rd request:
  - With macro → valid card delivered and `cards_left` = 51.
  - Without macro → ack with `card_value` = 0 and `cards_left` = 0.
- Shuffle/reset:
  - `shuffle_req` and `p_req` in the same IDLE cycle → shuffle first (`cards_left` = 52), player served afterwards.
  - `rst` asserted during SCAN → `cards_left` returns to 52 and no ack is issued.
